// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and types for the ALU op sequencer: shift op codes,
// sequencer state encoding and settle-counter width.
package alu_pkg;

  localparam logic [3:0] ALU_OP_SHL = 4'h8;
  localparam logic [3:0] ALU_OP_SHR = 4'h9;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU op sequencer.
// master = the sequencer; slave = requester + ALU + response consumer.
interface alu_op_sequencer_if #(
  parameter int bits = 8
);

  logic            req_valid;
  logic            req_ready;
  logic [bits-1:0] req_a;
  logic [bits-1:0] req_b;
  logic [3:0]      req_op;
  logic            req_flag_in;
  logic            req_chain;

  logic [bits-1:0] alu_a;
  logic [bits-1:0] alu_b;
  logic [3:0]      alu_control;
  logic            alu_flag_in;
  logic [bits-1:0] alu_result;
  logic            alu_c;
  logic            alu_flags;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [bits-1:0] rsp_result;
  logic            rsp_c;
  logic            rsp_flag;

  modport master (
    input  req_valid, req_a, req_b, req_op, req_flag_in, req_chain,
    output req_ready,
    output alu_a, alu_b, alu_control, alu_flag_in,
    input  alu_result, alu_c, alu_flags,
    output rsp_valid, rsp_result, rsp_c, rsp_flag,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, req_flag_in, req_chain,
    input  req_ready,
    input  alu_a, alu_b, alu_control, alu_flag_in,
    output alu_result, alu_c, alu_flags,
    input  rsp_valid, rsp_result, rsp_c, rsp_flag,
    output rsp_ready
  );

endinterface

// File: rtl/alu_op_sequencer_settle_cnt.sv
// Loadable 4-bit down-counter with zero flag; times the operand settle window.
module alu_settle_cnt
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU operand/result interface: IDLE -> ISSUE -> RESP.
// Optional operand chaining from the previous result when ALU_CHAIN_EN is defined.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int bits       = 8,
  parameter int SETTLE_CYC = 1
) (
  input logic                clk,
  input logic                rst_n,
  alu_op_sequencer_if.master bus
);

  localparam logic [1:0]       ST_IDLE     = IDLE;
  localparam logic [1:0]       ST_ISSUE    = ISSUE;
  localparam logic [1:0]       ST_RESP     = RESP;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]      r_state;
  logic [bits-1:0] r_alu_a;
  logic [bits-1:0] r_alu_b;
  logic [3:0]      r_alu_control;
  logic            r_alu_flag_in;
  logic            r_rsp_valid;
  logic [bits-1:0] r_rsp_result;
  logic            r_rsp_c;
  logic            r_rsp_flag;

  logic            w_accept;
  logic            w_capture;
  logic            w_cnt_dec;
  logic            w_cnt_zero;
  logic [bits-1:0] w_next_a;
  logic            w_next_flag_in;

  assign bus.req_ready = (r_state == ST_IDLE);
  assign w_accept      = bus.req_valid && (r_state == ST_IDLE);
  assign w_capture     = (r_state == ST_ISSUE) && w_cnt_zero;
  assign w_cnt_dec     = (r_state == ST_ISSUE) && !w_cnt_zero;

  alu_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

`ifdef ALU_CHAIN_EN
  logic [bits-1:0] r_last_result;
  logic            r_last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_result <= '0;
      r_last_c      <= 1'b0;
    end else if (w_capture) begin
      r_last_result <= bus.alu_result;
      r_last_c      <= bus.alu_c;
    end
  end

  assign w_next_a       = bus.req_chain ? r_last_result : bus.req_a;
  assign w_next_flag_in = bus.req_chain ? r_last_c      : bus.req_flag_in;
`else
  logic w_unused_chain;
  assign w_unused_chain = bus.req_chain;
  assign w_next_a       = bus.req_a;
  assign w_next_flag_in = bus.req_flag_in;
`endif

  // alu_* only change on accept, so the ALU sees stable operands between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_control <= '0;
      r_alu_flag_in <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_c       <= 1'b0;
      r_rsp_flag    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a       <= w_next_a;
            r_alu_b       <= bus.req_b;
            r_alu_control <= bus.req_op;
            r_alu_flag_in <= w_next_flag_in;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_capture) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_c      <= bus.alu_c;
            r_rsp_flag   <= bus.alu_flags;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_control = r_alu_control;
  assign bus.alu_flag_in = r_alu_flag_in;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_c       = r_rsp_c;
  assign bus.rsp_flag    = r_rsp_flag;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: two instances (settle 1 and settle 3)
// with an adder ALU stub; chaining steps compile in when ALU_CHAIN_EN is defined.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.bits(8)) bus0 ();
  alu_op_sequencer_if #(.bits(8)) bus1 ();

  alu_op_sequencer #(.bits(8), .SETTLE_CYC(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_op_sequencer #(.bits(8), .SETTLE_CYC(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ALU stub: result = a + b + flag_in, C = carry-out, flags = (result == 0)
  assign {bus0.alu_c, bus0.alu_result} = {1'b0, bus0.alu_a} + {1'b0, bus0.alu_b} + {8'd0, bus0.alu_flag_in};
  assign bus0.alu_flags = (bus0.alu_result == 8'd0);
  assign {bus1.alu_c, bus1.alu_result} = {1'b0, bus1.alu_a} + {1'b0, bus1.alu_b} + {8'd0, bus1.alu_flag_in};
  assign bus1.alu_flags = (bus1.alu_result == 8'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic f, input logic ch);
    bus0.req_a       = a;
    bus0.req_b       = b;
    bus0.req_op      = op;
    bus0.req_flag_in = f;
    bus0.req_chain   = ch;
  endtask

  // Single op on bus0: accept, bounded wait for response, consume it.
  task automatic run_op0(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic f, input logic ch, input logic [7:0] exp_alu_a,
                         input logic [7:0] exp_res);
    drive0(a, b, 4'h0, f, ch);
    bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    check({tag, "_alu_a"}, bus0.alu_a, exp_alu_a);
    for (int i = 0; i < 20 && !bus0.rsp_valid; i++) tick();
    check({tag, "_rsp_valid"}, bus0.rsp_valid, 1'b1);
    check({tag, "_rsp_result"}, bus0.rsp_result, exp_res);
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
  endtask

  logic [7:0] vec_a   [4] = '{8'h01, 8'h80, 8'h7F, 8'h00};
  logic [7:0] vec_b   [4] = '{8'h02, 8'h80, 8'h00, 8'h00};
  logic       vec_f   [4] = '{1'b0,  1'b1,  1'b0,  1'b0};
  logic [7:0] exp_res [4] = '{8'h03, 8'h01, 8'h7F, 8'h00};
  logic       exp_c   [4] = '{1'b0,  1'b1,  1'b0,  1'b0};
  logic       exp_flg [4] = '{1'b0,  1'b0,  1'b0,  1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_acc;
    int  n_rsp;
    int  last_acc;
    logic w_acc;
    logic w_rsp;

    rst_n          = 1'b0;
    bus0.req_valid = 1'b0; bus0.rsp_ready = 1'b0; drive0(8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    bus1.req_valid = 1'b0; bus1.rsp_ready = 1'b0;
    bus1.req_a = 8'h00; bus1.req_b = 8'h00; bus1.req_op = 4'h0;
    bus1.req_flag_in = 1'b0; bus1.req_chain = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_req_ready",  bus0.req_ready,   1'b1);
    check("rst_rsp_valid",  bus0.rsp_valid,   1'b0);
    check("rst_rsp_result", bus0.rsp_result,  8'h00);
    check("rst_alu_a",      bus0.alu_a,       8'h00);
    check("rst_alu_ctrl",   bus0.alu_control, 4'h0);

    // F0 + 20 + 1 = 0x111, response one edge after accept
    drive0(8'hF0, 8'h20, 4'h3, 1'b1, 1'b0);
    bus0.req_valid = 1'b1;
    check("t2_ready_pre", bus0.req_ready, 1'b1);
    tick();
    bus0.req_valid = 1'b0;
    check("t2_ready_busy",  bus0.req_ready,   1'b0);
    check("t2_no_rsp_yet",  bus0.rsp_valid,   1'b0);
    check("t2_alu_a",       bus0.alu_a,       8'hF0);
    check("t2_alu_b",       bus0.alu_b,       8'h20);
    check("t2_alu_ctrl",    bus0.alu_control, 4'h3);
    check("t2_alu_flag_in", bus0.alu_flag_in, 1'b1);
    tick();
    check("t2_rsp_valid",  bus0.rsp_valid,  1'b1);
    check("t2_rsp_result", bus0.rsp_result, 8'h11);
    check("t2_rsp_c",      bus0.rsp_c,      1'b1);
    check("t2_rsp_flag",   bus0.rsp_flag,   1'b0);
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    check("t2_rsp_cleared", bus0.rsp_valid,  1'b0);
    check("t2_ready_back",  bus0.req_ready,  1'b1);
    check("t2_rsp_held",    bus0.rsp_result, 8'h11);

    // FF + 01 + 0 = 0x100; response held under backpressure, new request ignored
    drive0(8'hFF, 8'h01, 4'h0, 1'b0, 1'b0);
    bus0.req_valid = 1'b1;
    tick();
    drive0(8'h55, 8'h66, 4'h7, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_rsp_valid",  bus0.rsp_valid,  1'b1);
      check("t3_rsp_result", bus0.rsp_result, 8'h00);
      check("t3_rsp_c",      bus0.rsp_c,      1'b1);
      check("t3_rsp_flag",   bus0.rsp_flag,   1'b1);
      check("t3_req_ready",  bus0.req_ready,  1'b0);
      check("t3_alu_a_held", bus0.alu_a,      8'hFF);
      tick();
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    check("t3_rsp_cleared", bus0.rsp_valid, 1'b0);
    check("t3_alu_a_kept",  bus0.alu_a,     8'hFF);
    check("t3_alu_b_kept",  bus0.alu_b,     8'h01);

    // SETTLE_CYC=3: D6 + 03 = D9, capture on the third edge after accept
    bus1.req_a = 8'hD6; bus1.req_b = 8'h03; bus1.req_op = ALU_OP_SHL;
    bus1.req_flag_in = 1'b0; bus1.req_valid = 1'b1;
    tick();
    bus1.req_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      check("t4_alu_ctrl_held", bus1.alu_control, 4'h8);
      check("t4_no_rsp",        bus1.rsp_valid,   1'b0);
      tick();
    end
    check("t4_rsp_valid",  bus1.rsp_valid,   1'b1);
    check("t4_rsp_result", bus1.rsp_result,  8'hD9);
    check("t4_rsp_c",      bus1.rsp_c,       1'b0);
    check("t4_rsp_flag",   bus1.rsp_flag,    1'b0);
    check("t4_alu_ctrl",   bus1.alu_control, 4'h8);
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    check("t4_rsp_cleared", bus1.rsp_valid, 1'b0);

    // Reset asserted mid-ISSUE: outputs clear without waiting for a clock edge
    bus1.req_a = 8'h12; bus1.req_b = 8'h34; bus1.req_op = 4'h5;
    bus1.req_flag_in = 1'b1; bus1.req_valid = 1'b1;
    tick();
    bus1.req_valid = 1'b0;
    check("t1_alu_a_issued", bus1.alu_a, 8'h12);
    #2 rst_n = 1'b0;
    #1;
    check("t1_alu_a",      bus1.alu_a,       8'h00);
    check("t1_alu_b",      bus1.alu_b,       8'h00);
    check("t1_alu_ctrl",   bus1.alu_control, 4'h0);
    check("t1_alu_flag",   bus1.alu_flag_in, 1'b0);
    check("t1_rsp_valid",  bus1.rsp_valid,   1'b0);
    check("t1_rsp_result", bus1.rsp_result,  8'h00);
    check("t1_req_ready",  bus1.req_ready,   1'b1);
    check("t1_dut0_alu_a", bus0.alu_a,       8'h00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_op_discarded", bus1.rsp_valid, 1'b0);
    end

    // Back-to-back ops on bus0 with rsp_ready held high
    n_acc = 0; n_rsp = 0; last_acc = -1;
    bus0.rsp_ready = 1'b1;
    drive0(vec_a[0], vec_b[0], 4'h1, vec_f[0], 1'b0);
    bus0.req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
      w_acc = bus0.req_valid && bus0.req_ready;
      w_rsp = bus0.rsp_valid && bus0.rsp_ready;
      if (w_rsp) begin
        check("t5_rsp_result", bus0.rsp_result, exp_res[n_rsp]);
        check("t5_rsp_c",      bus0.rsp_c,      exp_c[n_rsp]);
        check("t5_rsp_flag",   bus0.rsp_flag,   exp_flg[n_rsp]);
        n_rsp++;
      end
      if (w_acc) begin
        if (last_acc >= 0) check("t5_accept_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        n_acc++;
      end
      tick();
      if (w_acc) begin
        if (n_acc < 4) drive0(vec_a[n_acc], vec_b[n_acc], 4'h1, vec_f[n_acc], 1'b0);
        else bus0.req_valid = 1'b0;
      end
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b0;
    check("t5_accepts",   n_acc, 4);
    check("t5_responses", n_rsp, 4);
    tick();
    check("t5_no_extra_rsp", bus0.rsp_valid, 1'b0);

`ifdef ALU_CHAIN_EN
    run_op0("t6_op1", 8'h10, 8'h05, 1'b0, 1'b0, 8'h10, 8'h15);
    run_op0("t6_op2", 8'hAA, 8'h01, 1'b1, 1'b1, 8'h15, 8'h16);
`else
    run_op0("t6_chain_ignored", 8'h20, 8'h01, 1'b0, 1'b1, 8'h20, 8'h21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
